// File: rtl/high_run_logger.sv
// rtl/high_run_logger.sv - measures high runs of det, tags them with an ID and queues them in a FWFT FIFO
// Records drain through rec_valid/rec_ready; dropped records set a sticky overflow flag.
module high_run_logger #(
  parameter int LEN_W = 8,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det,
  input  logic             rec_ready,
  input  logic             clr_ovf,
  output logic             rec_valid,
  output logic [ID_W-1:0]  rec_id,
  output logic [LEN_W-1:0] rec_len,
  output logic             in_run,
  output logic             overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int REC_W = ID_W + LEN_W;
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [ID_W-1:0]    id;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  logic               empty, full, push, pop, push_ok, drop, has_next;
  logic [REC_W-1:0]   head_next;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = (state == RUN) && !det;
  assign pop     = !empty && rec_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign rec_valid = !empty;
  assign in_run    = (state == RUN);

  // The head registers track whatever sits at the read pointer after this edge,
  // including a record written on this same edge into an empty FIFO.
  always_comb begin
    rd_next  = rd_ptr + PW'(pop);
    wr_next  = wr_ptr + PW'(push_ok);
    has_next = (wr_next != rd_next);
    if (push_ok && (rd_next == wr_ptr))
      head_next = {id, len};
    else
      head_next = mem[rd_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= {id, len};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      len      <= '0;
      id       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rec_id   <= '0;
      rec_len  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (det) begin
            state <= RUN;
            len   <= LEN_W'(1);
          end
        end
        RUN: begin
          if (det) begin
            len <= (len == LEN_MAX) ? LEN_MAX : len + LEN_W'(1);
          end else begin
            id    <= id + ID_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      if (has_next)
        {rec_id, rec_len} <= head_next;

      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_high_run_logger.sv
// tb/tb_high_run_logger.sv - directed table and corner-case sequences for high_run_logger
module tb_high_run_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       det = 1'b0;
  logic       rec_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       rec_valid;
  logic [3:0] rec_id;
  logic [7:0] rec_len;
  logic       in_run;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  high_run_logger #(.LEN_W(8), .ID_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .det(det), .rec_ready(rec_ready), .clr_ovf(clr_ovf),
    .rec_valid(rec_valid), .rec_id(rec_id), .rec_len(rec_len),
    .in_run(in_run), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       det;
    logic       ready;
    logic       clr;
    logic       valid;
    logic [3:0] id;
    logic [7:0] len;
    logic       run;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step(input logic d, input logic r, input logic c);
    det = d; rec_ready = r; clr_ovf = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 0, 0);
    rst = 1'b1;
  endtask

  task automatic run_len(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1, r, 0);
    step(0, r, 0);
  endtask

  logic [3:0] hold_id;
  logic [7:0] hold_len;
  logic       was_valid, was_ready;
  int         pops;

  initial begin
    // rst det rdy clr | valid id len run ovf
    vecs.push_back('{0, 0, 0, 0, 0, 4'd0, 8'd0, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 4'd0, 8'd0, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 4'd0, 8'd0, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 4'd0, 8'd0, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 4'd0, 8'd0, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 4'd0, 8'd0, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 1, 4'd0, 8'd5, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 0, 4'd0, 8'd5, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 0, 4'd0, 8'd5, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 0, 4'd0, 8'd5, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 4'd1, 8'd1, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 4'd1, 8'd1, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 4'd1, 8'd1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 1, 4'd2, 8'd1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 0, 4'd2, 8'd1, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 0, 4'd2, 8'd1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      step(vecs[i].det, vecs[i].ready, vecs[i].clr);
      chk($sformatf("table[%0d]", i),
          {17'd0, rec_valid, rec_id, rec_len, in_run, overflow},
          {17'd0, vecs[i].valid, vecs[i].id, vecs[i].len, vecs[i].run, vecs[i].ovf});
    end
    rst = 1'b1;

    // Saturation
    do_reset();
    run_len(300, 1);
    chk("sat_valid", rec_valid, 1);
    chk("sat_id", rec_id, 0);
    chk("sat_len", rec_len, 255);
    chk("sat_ovf", overflow, 0);

    // Overflow and ID gaps
    do_reset();
    for (int i = 0; i < 5; i++) run_len(2, 0);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain_valid%0d", i), rec_valid, 1);
      chk($sformatf("ovf_drain_id%0d", i), rec_id, i);
      chk($sformatf("ovf_drain_len%0d", i), rec_len, 2);
      step(0, 1, 0);
    end
    chk("ovf_empty", rec_valid, 0);
    run_len(2, 0);
    chk("ovf_next_id", rec_id, 5);
    chk("ovf_still_set", overflow, 1);
    step(0, 0, 1);
    chk("ovf_cleared", overflow, 0);

    // Simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 4; i++) run_len(2, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("pp_ovf", overflow, 0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pp_drain_id%0d", i), rec_id, i);
      chk($sformatf("pp_drain_valid%0d", i), rec_valid, 1);
      step(0, 1, 0);
    end
    chk("pp_empty", rec_valid, 0);

    // Backpressure stability
    do_reset();
    run_len(1, 0);
    run_len(3, 0);
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      was_valid = rec_valid;
      hold_id   = rec_id;
      hold_len  = rec_len;
      was_ready = 1'($urandom_range(0, 1));
      if (was_valid && was_ready) begin
        chk($sformatf("bp_pop_id%0d", pops), hold_id, pops);
        chk($sformatf("bp_pop_len%0d", pops), hold_len, (pops == 0) ? 1 : 3);
        pops++;
      end
      step(0, was_ready, 0);
      if (was_valid && !was_ready)
        chk("bp_stable", {rec_id, rec_len}, {hold_id, hold_len});
    end
    for (int i = 0; i < 3; i++) begin
      if (rec_valid) begin
        chk($sformatf("bp_pop_id%0d", pops), rec_id, pops);
        pops++;
      end
      step(0, 1, 0);
    end
    chk("bp_pops", pops, 2);
    chk("bp_empty", rec_valid, 0);

    // Reset mid-run
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;
    step(1, 0, 0);
    rst = 1'b1;
    chk("rmr_in_run", in_run, 0);
    chk("rmr_valid0", rec_valid, 0);
    run_len(2, 0);
    chk("rmr_valid", rec_valid, 1);
    chk("rmr_id", rec_id, 0);
    chk("rmr_len", rec_len, 2);
    step(0, 1, 0);
    chk("rmr_single", rec_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/high_run_logger.md
# high_run_logger

Downstream consumer of the 3-cycle-high detector's output `y`. It measures every high run of that signal in clock cycles and tags each run with a sequence ID. It queues one record per completed run in a small first-word-fall-through FIFO, and drains the FIFO through a valid/ready handshake. Dropped records are flagged sticky and show up as gaps in the IDs.

## Interface
- `LEN_W`, default 8: run-length field width; the length saturates at 2^LEN_W-1.
- `ID_W`, default 4: sequence-ID width; the ID wraps modulo 2^ID_W.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `det`, in, 1: detector output `y`; sampled every cycle.
- `rec_ready`, in, 1: consumer accepts the head record.
- `clr_ovf`, in, 1: clears `overflow`.
- `rec_valid`, out, 1: FIFO is non-empty.
- `rec_id`, out, ID_W: ID of the head record.
- `rec_len`, out, LEN_W: length of the head record.
- `in_run`, out, 1: FSM is in the RUN state.
- `overflow`, out, 1: sticky flag; at least one record was dropped.

## Operation
- **Reset.** On an edge with `rst`=0:
  - FSM goes to IDLE; the length counter and `id` go to 0.
  - FIFO is emptied.
  - Outputs: `rec_valid`=0, `rec_id`=0, `rec_len`=0, `in_run`=0, `overflow`=0.
  - A run in progress is discarded and no record is produced.
- **FSM states: IDLE and RUN.**
  - IDLE with `det`=1: go to RUN; `len`<=1.
  - IDLE with `det`=0: stay in IDLE.
  - RUN with `det`=1: stay in RUN; `len`<=min(`len`+1, 2^LEN_W-1).
  - RUN with `det`=0: push {`id`, `len`}; `id`<=`id`+1 (wraps); go to IDLE.
- **Run length.** A run is the number of consecutive cycles `det`=1 was sampled. The minimum length is 1.
- **`id` on drop.** `id` increments on every completed run, including dropped ones.
- **Push while full.**
  - If a pop happens on the same edge, the push is accepted (one slot is freed).
  - Otherwise the record is dropped and `overflow`<=1.
- **Pop.** A pop occurs when `rec_valid` && `rec_ready`. The head advances.
- **Empty FIFO.** `rec_ready` is don't-care while `rec_valid`=0; pop is ignored when empty.
- **Push and pop on the same edge.** Both take effect; occupancy is unchanged.
- **Backpressure.** While `rec_valid`=1 and `rec_ready`=0, `rec_id`/`rec_len` hold stable.
- **Empty FIFO outputs.** While empty, `rec_id`/`rec_len` hold their last value; 0 after reset.
- **`overflow` clear vs set.**
  - `clr_ovf`=1 clears `overflow` on the next edge.
  - If a drop occurs on the same edge, set wins and `overflow` stays 1.
- **FIFO implementation.** Pointers are log2(DEPTH)+1 bits; full/empty are decoded from the MSB comparison. Occupancy is always between 0 and DEPTH.

## Timing
- **`in_run`.** Rises in the cycle after the first `det`=1 sample. Falls in the cycle after the first `det`=0 sample.
- **Record latency.** The record is written on the edge that samples the first `det`=0 after a run. `rec_valid`=1 in the following cycle: one cycle after `det` falls, if the FIFO was empty.
- **Back-to-back runs.** A `det` pattern of 1,0,1 produces two records of length 1.
- **Isolated 0 inside a run.** It ends the run and the next 1 starts a new run. The block does no filtering.
- **Pop timing.** A pop on edge N shows the next head (or `rec_valid`=0) in cycle N+1.
- **Throughput.** The shortest run-plus-gap is 2 cycles, so at most one push every 2 cycles. With `rec_ready` held at 1, the FIFO never fills.
- **Reset mid-operation.** Everything clears on that edge, including buffered records.

## Test plan
- **Single run.** After reset, `rec_ready`=1, `det` high for 5 cycles then low.
  - Required: one record, id 0, len 5.
  - `rec_valid` is high for exactly 1 cycle, in the cycle after the first low sample of `det`.
- **Saturation.** `LEN_W`=8, `det` high for 300 cycles.
  - Required: one record with len 255; `overflow`=0.
- **Overflow and ID gaps.** `rec_ready`=0; five runs of length 2, each separated by 1 low cycle.
  - Required: `overflow`=1 and 4 records held.
  - Drain then yields ids 0,1,2,3, all len 2.
  - A following run yields id 5.
  - Pulsing `clr_ovf` clears `overflow`.
- **Simultaneous push and pop while full.** FIFO full (ids 0–3). Assert `rec_ready`=1 for exactly the edge on which run id 4 completes.
  - Required: no drop, `overflow` stays 0.
  - Subsequent drain yields ids 1,2,3,4.
- **Backpressure stability.** Two records queued; toggle `rec_ready` randomly.
  - Required: `rec_id`/`rec_len` are unchanged while valid && !ready.
  - Exactly 2 pops occur, in order.
- **Reset mid-run.** `det` high for 3 cycles, then `rst`=0 for 1 cycle with `det` still high, then `det` high for 2 more cycles, then low.
  - Required: a single record, id 0, len 2.
  - `in_run` is 0 in the cycle after reset.
